pwm_gen: RTL and testbench



---
 rtl/motor_pkg.sv | 24 ++
 rtl/sync2.sv | 28 ++
 rtl/pwm_gen.sv | 183 ++++++++++++++++++
 tb/tb_pwm_gen.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared definitions for the motor-driver datapath: controller state
// encoding, default duty resolution and default clock/PWM frequencies.
package motor_pkg;

    // Duty resolution in bits; a PWM period has 2**DUTY_W steps.
    localparam int DUTY_W = 8;

    // Default system clock and PWM output frequencies in Hz.
    localparam int DEF_CLK_HZ = 100_000_000;
    localparam int DEF_PWM_HZ = 1000;

    // Controller state; the encoding is shared with the driver top level.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } pwm_state_t;

    // Clock cycles per PWM step, truncated (390 at the defaults).
    function automatic int calc_div(input int clk_hz, input int pwm_hz, input int duty_w);
        return clk_hz / (pwm_hz * (1 << duty_w));
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous board inputs, parameterized by width.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    import motor_pkg::*;

    logic [WIDTH-1:0] meta_p0;
    logic [WIDTH-1:0] sync_p1;

    // First flop may go metastable; second flop gives it a full cycle to settle.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            meta_p0 <= d;
            sync_p1 <= meta_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/pwm_gen.sv
// Soft-start PWM generator with overcurrent latch-off.
// The prescaler divides the clock into PWM steps, the step counter walks one
// period, and the applied duty creeps toward the switch setting by one LSB
// every RAMP_PERIODS periods. An overcurrent trip parks the output low until
// the fault is cleared while the comparator is quiet.
module pwm_gen #(
    parameter int CLK_HZ       = motor_pkg::DEF_CLK_HZ,
    parameter int PWM_HZ       = motor_pkg::DEF_PWM_HZ,
    parameter int DUTY_W       = motor_pkg::DUTY_W,
    parameter int RAMP_PERIODS = 4,
    parameter int DIV          = motor_pkg::calc_div(CLK_HZ, PWM_HZ, DUTY_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DUTY_W-1:0] duty_sw,
    input  logic              overcurrent,
    input  logic              clear_fault,
    output logic              pulse,
    output logic              period_start,
    output logic [DUTY_W-1:0] duty_active,
    output logic              fault
);
    import motor_pkg::*;

    localparam int PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int RAMP_W  = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);
    localparam logic [RAMP_W-1:0]  RAMP_LAST  = RAMP_W'(RAMP_PERIODS - 1);
    localparam logic [DUTY_W-1:0]  STEP_LAST  = '1;

    // Synchronized copies of the asynchronous inputs.
    logic              enable_s;
    logic              overcurrent_s;
    logic [DUTY_W-1:0] duty_s;

    pwm_state_t         state;
    logic [PRESC_W-1:0] presc;
    logic [DUTY_W-1:0]  step;
    logic [RAMP_W-1:0]  ramp_cnt;
    logic [DUTY_W-1:0]  target;

    logic tick;
    logic wrap;

    sync2 #(.WIDTH(1)) u_sync_enable (
        .clk (clk),
        .rst (rst),
        .d   (enable),
        .q   (enable_s)
    );

    sync2 #(.WIDTH(DUTY_W)) u_sync_duty (
        .clk (clk),
        .rst (rst),
        .d   (duty_sw),
        .q   (duty_s)
    );

    sync2 #(.WIDTH(1)) u_sync_oc (
        .clk (clk),
        .rst (rst),
        .d   (overcurrent),
        .q   (overcurrent_s)
    );

    // One LSB toward the target; never steps past it.
    function automatic logic [DUTY_W-1:0] ramp_toward(
        input logic [DUTY_W-1:0] cur,
        input logic [DUTY_W-1:0] tgt
    );
        if (cur < tgt) begin
            return cur + DUTY_W'(1);
        end else if (cur > tgt) begin
            return cur - DUTY_W'(1);
        end else begin
            return cur;
        end
    endfunction

    // tick: prescaler wraps this cycle; wrap: the step counter goes 255 -> 0 on it.
    assign tick = (presc == PRESC_LAST);
    assign wrap = tick && (step == STEP_LAST);

    // Controller FSM with the prescaler, step/ramp counters and all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            presc        <= '0;
            step         <= '0;
            ramp_cnt     <= '0;
            target       <= '0;
            duty_active  <= '0;
            pulse        <= 1'b0;
            period_start <= 1'b0;
            fault        <= 1'b0;
        end else begin
            period_start <= 1'b0;
            case (state)
                IDLE: begin
                    presc       <= '0;
                    step        <= '0;
                    ramp_cnt    <= '0;
                    target      <= '0;
                    duty_active <= '0;
                    pulse       <= 1'b0;
                    fault       <= 1'b0;
                    if (enable_s && !fault) begin
                        state <= RUN;
                    end
                end

                RUN: begin
                    if (overcurrent_s) begin
                        // A trip outranks both enable loss and a pending ramp step.
                        state       <= FAULT;
                        fault       <= 1'b1;
                        pulse       <= 1'b0;
                        duty_active <= '0;
                        presc       <= '0;
                        step        <= '0;
                        ramp_cnt    <= '0;
                        target      <= '0;
                    end else if (!enable_s) begin
                        state       <= IDLE;
                        pulse       <= 1'b0;
                        duty_active <= '0;
                        presc       <= '0;
                        step        <= '0;
                        ramp_cnt    <= '0;
                        target      <= '0;
                    end else begin
                        pulse <= (step < duty_active);
                        presc <= tick ? '0 : presc + PRESC_W'(1);
                        if (tick) begin
                            step <= step + DUTY_W'(1);
                        end
                        if (wrap) begin
                            // Period boundary: strobe, resample the switches and
                            // advance the ramp against the previously sampled target.
                            period_start <= 1'b1;
                            target       <= duty_s;
                            if (ramp_cnt == RAMP_LAST) begin
                                ramp_cnt    <= '0;
                                duty_active <= ramp_toward(duty_active, target);
                            end else begin
                                ramp_cnt <= ramp_cnt + RAMP_W'(1);
                            end
                        end
                    end
                end

                FAULT: begin
                    fault       <= 1'b1;
                    pulse       <= 1'b0;
                    duty_active <= '0;
                    presc       <= '0;
                    step        <= '0;
                    ramp_cnt    <= '0;
                    target      <= '0;
                    // Only release once the comparator has gone quiet.
                    if (clear_fault && !overcurrent_s) begin
                        state <= IDLE;
                        fault <= 1'b0;
                    end
                end

                default: begin
                    state       <= IDLE;
                    fault       <= 1'b0;
                    pulse       <= 1'b0;
                    duty_active <= '0;
                    presc       <= '0;
                    step        <= '0;
                    ramp_cnt    <= '0;
                    target      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_gen.sv
// Self-checking bench for pwm_gen: cycle-level reference model driven by
// elapsed-cycle arithmetic, plus scenario checks on the PWM waveform.
module tb_pwm_gen;
    localparam int DIV   = 2;
    localparam int RP    = 2;
    localparam int NSTEP = 256;
    localparam int P     = NSTEP * DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] duty_sw;
    logic       overcurrent;
    logic       clear_fault;
    logic       pulse;
    logic       period_start;
    logic [7:0] duty_active;
    logic       fault;

    int n_checks = 0;
    int n_fail   = 0;

    pwm_gen #(.DIV(DIV), .RAMP_PERIODS(RP)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .duty_sw      (duty_sw),
        .overcurrent  (overcurrent),
        .clear_fault  (clear_fault),
        .pulse        (pulse),
        .period_start (period_start),
        .duty_active  (duty_active),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    // Reference model state: 0 idle, 1 run, 2 fault.
    int m_state = 0;
    int run_cyc = 0;
    int m_duty = 0;
    int m_target = 0;
    int e_pulse = 0;
    int e_ps = 0;
    int e_fault = 0;
    bit en_h0 = 0, en_h1 = 0, oc_h0 = 0, oc_h1 = 0;
    int du_h0 = 0, du_h1 = 0;

    // Waveform bookkeeping.
    int cyc = 0;
    int hi_cnt = 0;
    int win_duty = 0;
    bit win_ok = 0;
    bit ps_seen = 0;
    int last_ps = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int toward(input int c, input int t);
        if (c < t) return c + 1;
        if (c > t) return c - 1;
        return c;
    endfunction

    task automatic model_update();
        bit en_s, oc_s;
        int d_s, stp;
        en_s = en_h1;
        oc_s = oc_h1;
        d_s  = du_h1;
        e_ps = 0;
        if (rst) begin
            en_h0 = 0; en_h1 = 0; oc_h0 = 0; oc_h1 = 0; du_h0 = 0; du_h1 = 0;
            m_state = 0; run_cyc = 0; m_duty = 0; m_target = 0;
            e_pulse = 0; e_fault = 0;
        end else begin
            en_h1 = en_h0; en_h0 = enable;
            oc_h1 = oc_h0; oc_h0 = overcurrent;
            du_h1 = du_h0; du_h0 = int'(duty_sw);
            case (m_state)
                0: begin
                    e_pulse = 0; e_fault = 0; m_duty = 0;
                    if (en_s) begin
                        m_state = 1; run_cyc = 0; m_target = 0;
                    end
                end
                1: begin
                    if (oc_s) begin
                        m_state = 2; e_fault = 1; e_pulse = 0; m_duty = 0;
                    end else if (!en_s) begin
                        m_state = 0; e_pulse = 0; m_duty = 0;
                    end else begin
                        stp = (run_cyc / DIV) % NSTEP;
                        e_pulse = (stp < m_duty) ? 1 : 0;
                        run_cyc++;
                        if (run_cyc % P == 0) begin
                            e_ps = 1;
                            if ((run_cyc / P) % RP == 0) m_duty = toward(m_duty, m_target);
                            m_target = d_s;
                        end
                    end
                end
                default: begin
                    e_pulse = 0; m_duty = 0; e_fault = 1;
                    if (clear_fault && !oc_s) begin
                        m_state = 0; e_fault = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        cyc++;
        check("pulse", {31'd0, pulse}, 32'(e_pulse));
        check("period_start", {31'd0, period_start}, 32'(e_ps));
        check("duty_active", {24'd0, duty_active}, 32'(m_duty));
        check("fault", {31'd0, fault}, 32'(e_fault));
        if (e_ps == 1) begin
            if (win_ok) check("high_cycles_per_period", 32'(hi_cnt), 32'(DIV * win_duty));
            hi_cnt = 0;
            win_duty = m_duty;
            win_ok = (m_state == 1);
        end
        if (pulse === 1'b1) hi_cnt++;
        if (period_start === 1'b1) begin
            if (ps_seen) check("period_start_spacing", 32'(cyc - last_ps), 32'(P));
            ps_seen = 1;
            last_ps = cyc;
        end
        if (m_state != 1) begin
            win_ok = 0;
            ps_seen = 0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_ps(input int limit);
        bit found;
        found = 0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (period_start === 1'b1) begin
                found = 1;
                break;
            end
        end
        check("period_start_timeout", {31'd0, found}, 32'd1);
    endtask

    initial begin
        int t1, t2, lat, hi, nps;
        bit found;

        rst = 1'b1; enable = 1'b0; duty_sw = 8'd0; overcurrent = 1'b0; clear_fault = 1'b0;
        run(3);
        check("reset_pulse", {31'd0, pulse}, 32'd0);
        check("reset_duty", {24'd0, duty_active}, 32'd0);
        check("reset_fault", {31'd0, fault}, 32'd0);
        check("reset_period_start", {31'd0, period_start}, 32'd0);
        rst = 1'b0;
        run(4);

        // Soft start toward a random setting, then hold.
        t1 = $urandom_range(12, 20);
        duty_sw = 8'(t1);
        enable = 1'b1;
        run((2 * t1 + 3) * P);
        check("ramp_up_holds_at_target", {24'd0, duty_active}, 32'(t1));

        // Lower the setting mid-period: nothing moves before the boundary.
        run($urandom_range(50, P - 50));
        t2 = t1 - $urandom_range(4, 8);
        duty_sw = 8'(t2);
        wait_ps(P + 8);
        check("no_change_before_boundary", {24'd0, duty_active}, 32'(t1));
        run((2 * (t1 - t2) + 4) * P);
        check("ramp_down_holds_at_target", {24'd0, duty_active}, 32'(t2));

        // Three-cycle overcurrent pulse while running.
        run($urandom_range(20, P - 20));
        overcurrent = 1'b1;
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            if (k == 4) overcurrent = 1'b0;
            tick();
            if (fault === 1'b1 && lat == 0) lat = k;
        end
        check("fault_within_3_cycles", 32'(lat >= 1 && lat <= 3), 32'd1);
        run(20);
        check("fault_sticky", {31'd0, fault}, 32'd1);
        check("fault_pulse_low", {31'd0, pulse}, 32'd0);

        // Clear while the comparator is still tripped is ignored.
        overcurrent = 1'b1;
        run(3);
        clear_fault = 1'b1;
        run(6);
        check("clear_ignored_fault", {31'd0, fault}, 32'd1);
        check("clear_ignored_pulse", {31'd0, pulse}, 32'd0);
        overcurrent = 1'b0;
        run(4);
        check("clear_releases_fault", {31'd0, fault}, 32'd0);
        check("clear_duty_zero", {24'd0, duty_active}, 32'd0);
        clear_fault = 1'b0;
        run(4 * P);
        check("restart_ramps_from_zero", 32'(duty_active <= 8'd2), 32'd1);

        // Zero duty: no pulses at all, period strobes every P cycles.
        enable = 1'b0;
        duty_sw = 8'd0;
        run(6);
        enable = 1'b1;
        hi = 0;
        nps = 0;
        for (int i = 0; i < 5 * P; i++) begin
            tick();
            if (pulse === 1'b1) hi++;
            if (period_start === 1'b1) nps++;
        end
        check("duty0_no_pulse", 32'(hi), 32'd0);
        check("duty0_period_count", 32'(nps), 32'd4);

        // Reset while the pulse is high.
        duty_sw = 8'(t1);
        run(5 * P);
        found = 0;
        for (int i = 0; i < 2 * P; i++) begin
            tick();
            if (pulse === 1'b1) begin
                found = 1;
                break;
            end
        end
        check("pulse_seen_before_reset", {31'd0, found}, 32'd1);
        rst = 1'b1;
        tick();
        check("midperiod_reset_pulse", {31'd0, pulse}, 32'd0);
        check("midperiod_reset_duty", {24'd0, duty_active}, 32'd0);
        check("midperiod_reset_fault", {31'd0, fault}, 32'd0);
        rst = 1'b0;
        run(P);

        // Reset together with clear during a fault.
        overcurrent = 1'b1;
        run(5);
        check("fault_before_reset", {31'd0, fault}, 32'd1);
        rst = 1'b1;
        clear_fault = 1'b1;
        tick();
        check("reset_in_fault_clears", {31'd0, fault}, 32'd0);
        check("reset_in_fault_pulse", {31'd0, pulse}, 32'd0);
        rst = 1'b0;
        clear_fault = 1'b0;
        overcurrent = 1'b0;
        run(5);

        // Random traffic on every input.
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            if ($urandom_range(0, 699) == 0) duty_sw = 8'($urandom_range(0, 255));
            overcurrent = ($urandom_range(0, 399) == 0);
            clear_fault = ($urandom_range(0, 49) == 0);
            rst = ($urandom_range(0, 2999) == 0);
            tick();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
